// File: rtl/riscvstall_inst_decode_queue_pkg.sv
// Shared riscvstall instruction-message definitions: format codes, opcode
// constants and field/format helpers used by the decode queue.
package riscvstall_inst_decode_queue_pkg;

    typedef enum logic [2:0] {
        RISCV_INST_FMT_R   = 3'd0,
        RISCV_INST_FMT_I   = 3'd1,
        RISCV_INST_FMT_S   = 3'd2,
        RISCV_INST_FMT_SB  = 3'd3,
        RISCV_INST_FMT_U   = 3'd4,
        RISCV_INST_FMT_UJ  = 3'd5,
        RISCV_INST_FMT_ILL = 3'd7
    } inst_fmt_e;

    localparam logic [6:0] RISCV_OPC_OP     = 7'b0110011;
    localparam logic [6:0] RISCV_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] RISCV_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] RISCV_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] RISCV_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] RISCV_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] RISCV_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] RISCV_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] RISCV_OPC_JAL    = 7'b1101111;

    localparam int unsigned RISCV_INST_MSG_SZ = 32;

    function automatic inst_fmt_e opcode_to_fmt(input logic [6:0] opc);
        inst_fmt_e f;
        case (opc)
            RISCV_OPC_OP:                                   f = RISCV_INST_FMT_R;
            RISCV_OPC_OP_IMM, RISCV_OPC_LOAD, RISCV_OPC_JALR: f = RISCV_INST_FMT_I;
            RISCV_OPC_STORE:                                f = RISCV_INST_FMT_S;
            RISCV_OPC_BRANCH:                               f = RISCV_INST_FMT_SB;
            RISCV_OPC_LUI, RISCV_OPC_AUIPC:                 f = RISCV_INST_FMT_U;
            RISCV_OPC_JAL:                                  f = RISCV_INST_FMT_UJ;
            default:                                        f = RISCV_INST_FMT_ILL;
        endcase
        return f;
    endfunction

    function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

endpackage

// File: rtl/riscvstall_inst_decode_queue_immgen.sv
// Combinational format classifier and immediate generator sitting in the
// enqueue path of the decode queue.
module riscvstall_InstImmGen
    import riscvstall_inst_decode_queue_pkg::*;
(
    input  logic [31:0] inst,
    output logic [2:0]  fmt,
    output logic [31:0] imm
);

    inst_fmt_e fmt_s;

    // Classify by opcode and assemble the sign-extended immediate for that format
    always_comb begin
        fmt_s = opcode_to_fmt(inst[6:0]);
        imm   = 32'd0;
        case (fmt_s)
            RISCV_INST_FMT_I:  imm = {{20{inst[31]}}, inst[31:20]};
            RISCV_INST_FMT_S:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            RISCV_INST_FMT_SB: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            RISCV_INST_FMT_U:  imm = {inst[31:12], 12'd0};
            RISCV_INST_FMT_UJ: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:           imm = 32'd0;
        endcase
        fmt = fmt_s;
    end

endmodule

// File: rtl/riscvstall_inst_decode_queue.sv
// Instruction decode queue: circular buffer of fetched words with their PCs,
// pre-decoded format and immediate, squashable by a flush.
module riscvstall_inst_decode_queue
    import riscvstall_inst_decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_SZ = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     enq_val,
    output logic                     enq_rdy,
    input  logic [PC_SZ-1:0]         enq_pc,
    input  logic [31:0]              enq_inst,
    output logic                     deq_val,
    input  logic                     deq_rdy,
    output logic [PC_SZ-1:0]         deq_pc,
    output logic [31:0]              deq_inst,
    output logic [2:0]               deq_fmt,
    output logic [6:0]               deq_opcode,
    output logic [4:0]               deq_rd,
    output logic [4:0]               deq_rs1,
    output logic [4:0]               deq_rs2,
    output logic [31:0]              deq_imm,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PC_SZ-1:0] pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic [2:0]       fmt_mem_q  [DEPTH];
    logic [31:0]      imm_mem_q  [DEPTH];

    logic        enq_fire_s;
    logic        deq_fire_s;
    logic [2:0]  enq_fmt_s;
    logic [31:0] enq_imm_s;
    logic [31:0] head_inst_s;

    riscvstall_InstImmGen u_immgen (
        .inst (enq_inst),
        .fmt  (enq_fmt_s),
        .imm  (enq_imm_s)
    );

    // Handshake: readiness never depends on deq_rdy, so a full queue stalls enqueue
    always_comb begin
        enq_rdy    = (count_q < CNT_W'(DEPTH)) && !flush && !reset;
        deq_val    = (count_q != {CNT_W{1'b0}}) && !flush && !reset;
        enq_fire_s = enq_val && enq_rdy;
        deq_fire_s = deq_val && deq_rdy;
    end

    // Pointer and occupancy next state; flush discards anything offered this cycle
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (enq_fire_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (deq_fire_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({enq_fire_s, deq_fire_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers; reset outranks flush
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is intentionally left unreset; only valid slots are ever read out
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            pc_mem_q[tail_q]   <= enq_pc;
            inst_mem_q[tail_q] <= enq_inst;
            fmt_mem_q[tail_q]  <= enq_fmt_s;
            imm_mem_q[tail_q]  <= enq_imm_s;
        end
    end

    // Head presentation, forced to zero whenever the head is not valid
    always_comb begin
        head_inst_s = inst_mem_q[head_q];
        deq_pc      = {PC_SZ{1'b0}};
        deq_inst    = 32'd0;
        deq_fmt     = 3'd0;
        deq_opcode  = 7'd0;
        deq_rd      = 5'd0;
        deq_rs1     = 5'd0;
        deq_rs2     = 5'd0;
        deq_imm     = 32'd0;
        if (deq_val) begin
            deq_pc     = pc_mem_q[head_q];
            deq_inst   = head_inst_s;
            deq_fmt    = fmt_mem_q[head_q];
            deq_opcode = inst_opcode(head_inst_s);
            deq_rd     = inst_rd(head_inst_s);
            deq_rs1    = inst_rs1(head_inst_s);
            deq_rs2    = inst_rs2(head_inst_s);
            deq_imm    = imm_mem_q[head_q];
        end else begin
            deq_pc     = {PC_SZ{1'b0}};
        end
        count = count_q;
    end

endmodule

// File: doc/riscvstall_inst_decode_queue.md
# riscvstall_inst_decode_queue

Parametrised instruction decode queue for the riscvstall fetch/decode boundary. It buffers up to DEPTH fetched 32-bit instruction words with their PCs. Each word is classified into its RISC-V format (R/I/S/SB/U/UJ) at enqueue, and the register fields and sign-extended 32-bit immediate are extracted and stored with it. It replaces ad-hoc per-stage field slicing and supports a squash (flush) from the branch-resolution stage.

## Interface

Parameters:
- DEPTH, 4: number of entries. Power of two, 2 to 16.
- PC_SZ, 32: PC width.

Ports:
- clk, in, 1: sole clock. Reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high.
- flush, in, 1: squash all entries.
- enq_val, in, 1: input instruction valid.
- enq_rdy, out, 1: queue can accept.
- enq_pc, in, PC_SZ: PC of the input instruction.
- enq_inst, in, 32: raw instruction word (`RISCV_INST_MSG_SZ).
- deq_val, out, 1: head entry valid.
- deq_rdy, in, 1: consumer accepts the head.
- deq_pc, out, PC_SZ: head PC.
- deq_inst, out, 32: head raw instruction word.
- deq_fmt, out, 3: format code, R=0, I=1, S=2, SB=3, U=4, UJ=5, ILL=7.
- deq_opcode, out, 7: head opcode field.
- deq_rd, out, 5: head rd field.
- deq_rs1, out, 5: head rs1 field.
- deq_rs2, out, 5: head rs2 field.
- deq_imm, out, 32: decoded immediate.
- count, out, $clog2(DEPTH)+1: current occupancy.

## Operation

- Enqueue fires when enq_val && enq_rdy. Dequeue fires when deq_val && deq_rdy. Both may fire in the same cycle; count is then unchanged.
- enq_rdy = (count < DEPTH) && !flush && !reset. There is no combinational path from deq_rdy; a full queue does not accept an entry in the same cycle it dequeues one.
- deq_val = (count != 0) && !flush.
- Format decode, by opcode:
  - 0110011 → R
  - 0010011, 0000011, 1100111 (JALR) → I
  - 0100011 → S
  - 1100011 → SB
  - 0110111, 0010111 → U
  - 1101111 → UJ
  - anything else → ILL
- Immediate decode, using the existing `RISCV_INST_MSG_IMM_* field macros:
  - I: sext(inst[31:20])
  - S: sext({inst[31:25], inst[11:7]})
  - SB: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - U: {inst[31:12], 12'b0}
  - UJ: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - R and ILL: 0
- Storage is a circular buffer with head and tail pointers. Pointers wrap modulo DEPTH. Each entry holds pc, inst, fmt and imm. rd, rs1, rs2 and opcode are sliced from the stored inst.
- When deq_val=0, all deq_* data outputs read 0.
- flush: at the next edge, head, tail and count clear to 0. An enqueue or dequeue presented in the flush cycle has no effect. flush takes priority over both.
- reset has priority over flush. It clears the pointers and count. Storage contents are not reset.

## Timing

- Reset values (during and after reset): enq_rdy=0 while reset is high, then 1; deq_val=0; count=0; all deq_* data outputs 0.
- Latency: an entry enqueued at edge t is visible with deq_val=1 from cycle t+1. There is no same-cycle bypass from enq to deq.
- Throughput: one enqueue and one dequeue per cycle.
- Ordering: strict FIFO, including across pointer wrap-around.
- Full (count=DEPTH): enq_rdy=0; a dequeue still fires normally.
- Empty: deq_val=0; an enqueue fires normally.
- Reset or flush asserted mid-stream: the queue is empty at the next edge, and enq_rdy returns to 1 the cycle after the control signal deasserts.

## Structure

- The format codes (RISCV_INST_FMT_R through RISCV_INST_FMT_ILL) and the opcode constants are added to the shared riscvstall-InstMsg.v header, next to the existing field macros.
- One combinational sub-module, riscvstall_InstImmGen: input inst[31:0], outputs fmt[2:0] and imm[31:0]. It sits in the enqueue path.
- The queue body (pointers, count, storage array, output muxing) lives in riscvstall_inst_decode_queue.

## Test plan

- ADDI: enq_inst=0x8AD98793, pc=0x1000 → next cycle deq_fmt=1, deq_rd=15, deq_rs1=19, deq_imm=0xFFFFF8AD.
- LUI and BLT back-to-back:
  - 0xDEADB8B7 → fmt=4, rd=17, imm=0xDEADB000.
  - 0x80404E63 → fmt=3, rs1=0, rs2=4, imm=0xFFFFF01C.
  - Both dequeue in order.
- Fill and drain, DEPTH=4, deq_rdy=0: offer 5 words; enq_rdy drops after the 4th and count=4. Then deq_rdy=1 drains 4 words in order over 4 cycles. Repeat enough times to wrap the pointers twice.
- Simultaneous fire at count=2: enqueue and dequeue in the same cycle → count stays 2 and order is preserved.
- Flush with count=3, with enq_val=1 in the same cycle → next cycle count=0, deq_val=0, and the offered word is dropped.
- Illegal opcode: enq_inst=0x0000007F → deq_fmt=7, deq_imm=0.
- Reset asserted with count=3 → count=0 and deq_val=0 after the edge; enq_rdy=1 the cycle after reset deasserts.
